// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU plus a 32-step iterative unit for MUL, DIVU and REMU.
// Results and forwarded control fields are registered for the memory stage.
module exe_stage #(
    parameter int ITER_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  EXE_CMD,
    input  logic [31:0] val1,
    input  logic [31:0] val2,
    input  logic [31:0] ST_value,
    input  logic [4:0]  dest,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [1:0]  WB_EN,
    output logic [31:0] alu_result,
    output logic [31:0] ST_value_out,
    output logic [4:0]  dest_out,
    output logic        MEM_R_EN_out,
    output logic        MEM_W_EN_out,
    output logic [1:0]  WB_EN_out,
    output logic        stall,
    output logic [5:0]  dbg_state
);

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0001;
    localparam logic [3:0] CMD_AND  = 4'b0010;
    localparam logic [3:0] CMD_OR   = 4'b0011;
    localparam logic [3:0] CMD_NOR  = 4'b0100;
    localparam logic [3:0] CMD_XOR  = 4'b0101;
    localparam logic [3:0] CMD_SLL  = 4'b0110;
    localparam logic [3:0] CMD_SRA  = 4'b0111;
    localparam logic [3:0] CMD_SRL  = 4'b1000;
    localparam logic [3:0] CMD_SLT  = 4'b1001;
    localparam logic [3:0] CMD_MUL  = 4'b1010;
    localparam logic [3:0] CMD_DIVU = 4'b1011;
    localparam logic [3:0] CMD_REMU = 4'b1100;

    localparam logic [4:0] LAST_CNT = 5'(ITER_STEPS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [3:0]  cmd_q;
    logic [31:0] acc_q;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] st_q;
    logic [4:0]  dest_q;
    logic [1:0]  wb_q;
    logic        mr_q;
    logic        mw_q;

    logic        is_iter;
    logic [31:0] alu_comb;
    logic [31:0] mul_acc_next;
    logic [32:0] div_sh;
    logic [32:0] div_sub;
    logic        div_ge;
    logic [31:0] div_rem_next;
    logic [31:0] div_q_next;
    logic [31:0] iter_result;

    assign is_iter = (EXE_CMD == CMD_MUL) || (EXE_CMD == CMD_DIVU) || (EXE_CMD == CMD_REMU);

    // stall is the only flow control: while it is high the ID/EX register must hold,
    // and this stage ignores its inputs; the cycle stall drops, the presented op is consumed.
    assign stall = rst && (((state == IDLE) && is_iter) || ((state == BUSY) && (cnt != LAST_CNT)));

    assign dbg_state = {state == BUSY, cnt};

    always_comb begin
        alu_comb = '0;
        case (EXE_CMD)
            CMD_ADD: alu_comb = val1 + val2;
            CMD_SUB: alu_comb = val1 - val2;
            CMD_AND: alu_comb = val1 & val2;
            CMD_OR:  alu_comb = val1 | val2;
            CMD_NOR: alu_comb = ~(val1 | val2);
            CMD_XOR: alu_comb = val1 ^ val2;
            CMD_SLL: alu_comb = val1 << val2[4:0];
            CMD_SRA: alu_comb = $signed(val1) >>> val2[4:0];
            CMD_SRL: alu_comb = val1 >> val2[4:0];
            CMD_SLT: alu_comb = {31'b0, $signed(val1) < $signed(val2)};
            default: alu_comb = '0;
        endcase
    end

    // Shift-add multiply: acc accumulates op_a (shifted left) for each set bit of op_b.
    assign mul_acc_next = op_b[0] ? (acc_q + op_a) : acc_q;

    // Restoring division: acc holds the partial remainder, op_a shifts the dividend out
    // and the quotient in. A zero divisor always "fits", giving all-ones and rem = dividend.
    assign div_sh       = {acc_q, op_a[31]};
    assign div_sub      = div_sh - {1'b0, op_b};
    assign div_ge       = div_sh >= {1'b0, op_b};
    assign div_rem_next = div_ge ? div_sub[31:0] : div_sh[31:0];
    assign div_q_next   = {op_a[30:0], div_ge};

    always_comb begin
        iter_result = '0;
        case (cmd_q)
            CMD_MUL:  iter_result = mul_acc_next;
            CMD_DIVU: iter_result = div_q_next;
            CMD_REMU: iter_result = div_rem_next;
            default:  iter_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cmd_q        <= '0;
            acc_q        <= '0;
            op_a         <= '0;
            op_b         <= '0;
            st_q         <= '0;
            dest_q       <= '0;
            wb_q         <= '0;
            mr_q         <= 1'b0;
            mw_q         <= 1'b0;
            alu_result   <= '0;
            ST_value_out <= '0;
            dest_out     <= '0;
            MEM_R_EN_out <= 1'b0;
            MEM_W_EN_out <= 1'b0;
            WB_EN_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_iter) begin
                        state        <= BUSY;
                        cnt          <= '0;
                        cmd_q        <= EXE_CMD;
                        acc_q        <= '0;
                        op_a         <= val1;
                        op_b         <= val2;
                        st_q         <= ST_value;
                        dest_q       <= dest;
                        wb_q         <= WB_EN;
                        mr_q         <= MEM_R_EN;
                        mw_q         <= MEM_W_EN;
                        alu_result   <= '0;
                        ST_value_out <= '0;
                        dest_out     <= '0;
                        MEM_R_EN_out <= 1'b0;
                        MEM_W_EN_out <= 1'b0;
                        WB_EN_out    <= '0;
                    end else begin
                        alu_result   <= alu_comb;
                        ST_value_out <= ST_value;
                        dest_out     <= dest;
                        MEM_R_EN_out <= MEM_R_EN;
                        MEM_W_EN_out <= MEM_W_EN;
                        WB_EN_out    <= WB_EN;
                    end
                end
                BUSY: begin
                    if (cmd_q == CMD_MUL) begin
                        acc_q <= mul_acc_next;
                        op_a  <= op_a << 1;
                        op_b  <= op_b >> 1;
                    end else begin
                        acc_q <= div_rem_next;
                        op_a  <= div_q_next;
                    end
                    if (cnt == LAST_CNT) begin
                        state        <= IDLE;
                        cnt          <= '0;
                        alu_result   <= iter_result;
                        ST_value_out <= st_q;
                        dest_out     <= dest_q;
                        MEM_R_EN_out <= mr_q;
                        MEM_W_EN_out <= mw_q;
                        WB_EN_out    <= wb_q;
                    end else begin
                        cnt          <= cnt + 5'd1;
                        alu_result   <= '0;
                        ST_value_out <= '0;
                        dest_out     <= '0;
                        MEM_R_EN_out <= 1'b0;
                        MEM_W_EN_out <= 1'b0;
                        WB_EN_out    <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
